// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx : 16x-oversampled UART receiver, LSB first, one stop bit.
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int c_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               state_q;
  logic [3:0]           sub_q;
  logic [c_CNT_W-1:0]   bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 busy_q;
  logic                 rx_meta_q;
  logic                 rx_s_q;

  // Synchronizer presets to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sub_q       <= 4'd0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sub_q <= 4'd0;
          if (!rx_s_q) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_START: begin
          if (tick16) begin
            if (sub_q == 4'd7) begin
              if (!rx_s_q) begin
                sub_q     <= 4'd0;
                bit_cnt_q <= '0;
                state_q   <= S_DATA;
              end else begin
                sub_q   <= 4'd0;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end else begin
              sub_q <= sub_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick16) begin
            sub_q <= sub_q + 4'd1;
            if (sub_q == 4'd15) begin
              shreg_q   <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + c_CNT_W'(1);
              if (bit_cnt_q == c_LAST_BIT) begin
                state_q <= S_STOP;
              end
            end
          end
        end
        S_STOP: begin
          if (tick16) begin
            sub_q <= sub_q + 4'd1;
            if (sub_q == 4'd15) begin
              if (rx_s_q) begin
                dout_q  <= shreg_q;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end
          end
        end
        S_BREAK: begin
          // Stay busy until the line recovers; a low line here is not a start.
          if (rx_s_q) begin
            sub_q   <= 4'd0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          sub_q   <= 4'd0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_rx : randomized frame stimulus checked against an event-level model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick16;
  logic       rx;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick16   (tick16),
    .rx       (rx),
    .dout     (dout),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model_dout = 8'h00;
  logic [7:0] last_valid_data = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         tick_n = 2;
  int         tick_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the baud strobe is produced here so rx and tick16 stay aligned.
  task automatic step();
    @(negedge clk);
    if (tick_cnt >= tick_n - 1) begin
      tick16   = 1'b1;
      tick_cnt = 0;
    end else begin
      tick16 = 1'b0;
      tick_cnt++;
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      step();
      if (tick16) k++;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    ev_t e;
    e.is_err = ~stop_bit;
    e.data   = d;
    exp_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == 3) check("busy mid-frame", busy, 1);
    end
    send_bit(stop_bit);
  endtask

  task automatic flush();
    rx = 1'b1;
    wait_ticks(48);
    check("pending strobes", exp_q.size(), 0);
    check("busy idle", busy, 0);
  endtask

  task automatic set_rate(input int n);
    tick_n   = n;
    tick_cnt = 0;
  endtask

  // Compare process: every cycle, away from the active edge.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_q.delete();
        model_dout = 8'h00;
        check("reset outputs", {21'd0, dout, valid, frame_err, busy}, 0);
      end else begin
        check("strobe overlap", valid & frame_err, 0);
        if (valid || frame_err) begin
          if (exp_q.size() == 0) begin
            check("unexpected strobe", {valid, frame_err}, 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe kind", frame_err, e.is_err);
            if (valid && !e.is_err) begin
              model_dout      = e.data;
              last_valid_data = dout;
              n_valid++;
            end
            if (frame_err) n_ferr++;
          end
        end
        check("dout", dout, model_dout);
      end
    end
  end

  initial begin
    int v0;
    int f0;
    logic [7:0] d;
    logic [7:0] bad;
    rst    = 1'b1;
    rx     = 1'b1;
    tick16 = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    set_rate($urandom_range(2, 3));
    wait_ticks(32);

    // Single 0x55 frame
    send_frame(8'h55, 1'b1);
    flush();
    check("0x55 valid count", n_valid, 1);
    check("0x55 ferr count", n_ferr, 0);
    check("0x55 data", last_valid_data, 8'h55);

    // Back-to-back frames
    v0 = n_valid;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    flush();
    check("b2b valid count", n_valid - v0, 3);
    check("b2b last data", last_valid_data, 8'hFF);

    // Short low glitch: false start
    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    wait_ticks(4);
    check("busy during glitch", busy, 1);
    rx = 1'b1;
    wait_ticks(16);
    check("busy after false start", busy, 0);
    check("glitch valid count", n_valid - v0, 0);
    check("glitch ferr count", n_ferr - f0, 0);

    // Framing error, long break, then recovery
    v0 = n_valid;
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    wait_ticks(20 * 16);
    check("busy in break", busy, 1);
    check("dout kept after ferr", dout, 8'hFF);
    rx = 1'b1;
    wait_ticks(16);
    send_frame(8'h81, 1'b1);
    flush();
    check("break ferr count", n_ferr - f0, 1);
    check("break valid count", n_valid - v0, 1);
    check("post-break data", last_valid_data, 8'h81);

    // Reset during data bit 4 of 0x96
    v0 = n_valid;
    d  = 8'h96;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    wait_ticks(8);
    rst = 1'b1;
    repeat (4) step();
    rst = 1'b0;
    rx  = 1'b1;
    wait_ticks(32);
    send_frame(8'h5A, 1'b1);
    flush();
    check("post-reset valid count", n_valid - v0, 1);
    check("post-reset dout", dout, 8'h5A);

    // Random frames, occasional framing errors, random gaps
    set_rate($urandom_range(2, 3));
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        send_frame(d, 1'b0);
        rx = 1'b0;
        wait_ticks(16 * $urandom_range(2, 5));
        rx = 1'b1;
        wait_ticks(16);
      end else begin
        send_frame(d, 1'b1);
        rx = 1'b1;
        wait_ticks($urandom_range(0, 20));
      end
    end
    flush();

    // Full byte sweep at one tick per clock
    set_rate(1);
    v0 = n_valid;
    for (int b = 0; b < 256; b++) begin
      bad = 8'(b);
      send_frame(bad, 1'b1);
      rx = 1'b1;
      wait_ticks($urandom_range(0, 3));
    end
    flush();
    check("sweep valid count", n_valid - v0, 256);
    check("sweep last data", last_valid_data, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
